// File: rtl/player_ctrl_pkg.sv
// Shared types and default tuning constants for the player life-cycle sequencer.
package player_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ALIVE  = 3'd1,
    HIT    = 3'd2,
    INVULN = 3'd3,
    OVER   = 3'd4
  } player_state_t;

  localparam int PLAYER_LIVES         = 3;
  localparam int PLAYER_HIT_FRAMES    = 96;
  localparam int PLAYER_INVULN_FRAMES = 64;
  localparam int PLAYER_BLINK_SHIFT   = 3;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a level key input; one register plus an AND gate.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic level_i,
  output logic rise_o
);

  logic level_d1_q;
  logic level_d1_d;

  assign level_d1_d = level_i;

  // One-cycle delayed copy of the key level; cleared so a key held through reset reads as a fresh press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) level_d1_q <= 1'b0;
    else       level_d1_q <= level_d1_d;
  end

  assign rise_o = level_i & ~level_d1_q;

endmodule

// File: rtl/player_life_ctrl.sv
// Player life-cycle sequencer: standby, play, hit freeze, invulnerable respawn, game over.
module player_life_ctrl
  import player_ctrl_pkg::*;
#(
  parameter int LIVES         = PLAYER_LIVES,
  parameter int HIT_FRAMES    = PLAYER_HIT_FRAMES,
  parameter int INVULN_FRAMES = PLAYER_INVULN_FRAMES,
  parameter int BLINK_SHIFT   = PLAYER_BLINK_SHIFT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       enterKeyPressed,
  input  logic       playerHit,
  output logic       playGame,
  output logic       playerVisible,
  output logic [1:0] livesLeft,
  output logic       respawnPulse,
  output logic       gameEnded
);

  localparam logic [7:0] HIT_LAST    = 8'(HIT_FRAMES - 1);
  localparam logic [7:0] INVULN_LAST = 8'(INVULN_FRAMES - 1);
  localparam logic [2:0] BLINK_BIT   = 3'(BLINK_SHIFT);
  localparam logic [1:0] LIVES_INIT  = 2'(LIVES);

  logic          enter_rise;
  player_state_t state_q, state_d;
  logic [1:0]    lives_q, lives_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic          play_game_q, play_game_d;
  logic          visible_q, visible_d;
  logic          respawn_q, respawn_d;
  logic          ended_q, ended_d;

  rise_detect u_enter_rise (
    .clk     (clk),
    .reset   (reset),
    .level_i (enterKeyPressed),
    .rise_o  (enter_rise)
  );

  // Next-state, lives and frame-counter logic; hits only count while ALIVE.
  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    frame_cnt_d = frame_cnt_q;
    respawn_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enter_rise) begin
          state_d     = ALIVE;
          lives_d     = LIVES_INIT;
          frame_cnt_d = 8'd0;
        end
      end
      ALIVE: begin
        if (playerHit) begin
          frame_cnt_d = 8'd0;
          if (lives_q > 2'd1) begin
            state_d = HIT;
            lives_d = lives_q - 2'd1;
          end else begin
            state_d = OVER;
            lives_d = 2'd0;
          end
        end
      end
      HIT: begin
        if (startOfFrame) begin
          if (frame_cnt_q == HIT_LAST) begin
            state_d     = INVULN;
            frame_cnt_d = 8'd0;
            respawn_d   = 1'b1;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end
      INVULN: begin
        if (startOfFrame) begin
          if (frame_cnt_q == INVULN_LAST) begin
            state_d     = ALIVE;
            frame_cnt_d = 8'd0;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end
      OVER: begin
        if (enter_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the next state so they register in step with it.
  always_comb begin
    play_game_d = (state_d == ALIVE) || (state_d == INVULN);
    ended_d     = (state_d == OVER);
    visible_d   = 1'b1;
    case (state_d)
      HIT, INVULN: visible_d = ~frame_cnt_d[BLINK_BIT];
      OVER:        visible_d = 1'b0;
      default:     visible_d = 1'b1;
    endcase
  end

  // State, counters and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      lives_q     <= LIVES_INIT;
      frame_cnt_q <= 8'd0;
      play_game_q <= 1'b0;
      visible_q   <= 1'b1;
      respawn_q   <= 1'b0;
      ended_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      frame_cnt_q <= frame_cnt_d;
      play_game_q <= play_game_d;
      visible_q   <= visible_d;
      respawn_q   <= respawn_d;
      ended_q     <= ended_d;
    end
  end

  assign playGame      = play_game_q;
  assign playerVisible = visible_q;
  assign livesLeft     = lives_q;
  assign respawnPulse  = respawn_q;
  assign gameEnded     = ended_q;

endmodule
